// File: rtl/io_bank.sv
// io_bank: bidirectional I/O channels with synchroniser, glitch filter, edge pulses.
// Define IO_BANK_DDR_EN to add falling-edge output drive and input sampling.
module io_bank #(
    parameter int               WIDTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILTER_LEN  = 3,
    parameter logic [WIDTH-1:0] PULLUP      = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             resetn,
    inout  wire  [WIDTH-1:0] pin,
    output logic             global_out,
    input  logic             clock_enable,
    input  logic             latch_input,
    input  logic [WIDTH-1:0] output_enable,
    input  logic [WIDTH-1:0] d_out_0,
    input  logic [WIDTH-1:0] d_out_1,
    output logic [WIDTH-1:0] d_in_0,
    output logic [WIDTH-1:0] d_in_1,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CW = 4;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] edge_ref;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] drive;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pin;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_LEN == 0) begin : g_nofilt
            assign stable = sync_out;
        end else begin : g_filt
            logic [CW-1:0]    cnt [WIDTH];
            logic [WIDTH-1:0] stable_q;

            // A change is accepted once it has disagreed for FILTER_LEN edges
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    stable_q <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync_out[i] == stable_q[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
                            stable_q[i] <= sync_out[i];
                            cnt[i]      <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                end
            end

            assign stable = stable_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            edge_ref <= '0;
            rise     <= '0;
            fall     <= '0;
            d_in_0   <= '0;
            q0       <= '0;
            oe_q     <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            if (clock_enable) begin
                edge_ref <= stable;
                rise     <= stable & ~edge_ref;
                fall     <= ~stable & edge_ref;
                q0       <= d_out_0;
                oe_q     <= output_enable;
                if (!latch_input) begin
                    d_in_0 <= stable;
                end
            end
        end
    end

`ifdef IO_BANK_DDR_EN
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] neg_q;

    always_ff @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            neg_q <= '0;
        end else begin
            neg_q <= pin;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q1     <= '0;
            d_in_1 <= '0;
        end else if (clock_enable) begin
            q1 <= d_out_1;
            if (!latch_input) begin
                d_in_1 <= neg_q;
            end
        end
    end

    // High phase carries the rising-edge word, low phase the falling-edge word
    assign drive = clk ? q0 : q1;
`else
    logic unused_d_out_1;

    assign unused_d_out_1 = ^d_out_1;
    assign d_in_1         = '0;
    assign drive          = q0;
`endif

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_pin
            assign pin[i] = oe_q[i] ? drive[i] : 1'bz;
            if (PULLUP[i]) begin : g_pu
                pullup pu (pin[i]);
            end
        end
    endgenerate

    assign global_out = pin[0];

endmodule

// File: tb/tb_io_bank.sv
// tb_io_bank: randomized and directed checks of io_bank against a
// cycle-level behavioural model of sampling, filtering and pin resolution.
`timescale 1ns/1ps
module tb_io_bank;

    localparam int         W  = 4;
    localparam int         S  = 2;
    localparam int         F  = 3;
    localparam logic [3:0] PU = 4'b0010;

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic         ce     = 1'b1;
    logic         latch  = 1'b0;
    logic [W-1:0] oe_in  = '0;
    logic [W-1:0] dout0  = '0;
    logic [W-1:0] dout1  = '0;
    logic [W-1:0] ext_en = '1;
    logic [W-1:0] ext_val = '0;
    wire  [W-1:0] pin;
    logic         gout;
    logic [W-1:0] din0;
    logic [W-1:0] din1;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_ext
        assign pin[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    always #5 clk = ~clk;

    io_bank #(
        .WIDTH      (W),
        .SYNC_STAGES(S),
        .FILTER_LEN (F),
        .PULLUP     (PU)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pin          (pin),
        .global_out   (gout),
        .clock_enable (ce),
        .latch_input  (latch),
        .output_enable(oe_in),
        .d_out_0      (dout0),
        .d_out_1      (dout1),
        .d_in_0       (din0),
        .d_in_1       (din1),
        .rise         (rise),
        .fall         (fall)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_q0 = '0, m_q1 = '0, m_oe = '0;
    logic [W-1:0] m_din0 = '0, m_din1 = '0, m_rise = '0, m_fall = '0;
    logic [W-1:0] m_ref = '0, m_stab = '0, m_last = '0, m_nsamp = '0;
    logic [W-1:0] m_smp, m_sync, m_snow;
    int           m_run [W];
    logic [W-1:0] m_hist [$];

    // What the pin net carries while clk is low, and which bits are driven
    function automatic logic [W-1:0] pin_val();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) begin
            if (m_oe[i])       v[i] = m_q1[i];
            else if (ext_en[i]) v[i] = ext_val[i];
            else               v[i] = PU[i];
        end
        return v;
    endfunction

    function automatic logic [W-1:0] pin_known();
        return m_oe | ext_en | PU;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_q0 = '0; m_q1 = '0; m_oe = '0; m_din0 = '0; m_din1 = '0;
            m_rise = '0; m_fall = '0; m_ref = '0; m_stab = '0;
            m_last = '0; m_nsamp = '0;
            m_hist.delete();
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            m_smp  = pin_val();
            m_sync = (m_hist.size() >= S) ? m_hist[S-1] : '0;
            m_hist.push_front(m_smp);
            if (m_hist.size() > S) void'(m_hist.pop_back());
            for (int i = 0; i < W; i++) begin
                if (m_sync[i] == m_last[i]) m_run[i]++;
                else m_run[i] = 1;
            end
            m_last = m_sync;
            m_snow = (F == 0) ? m_sync : m_stab;
            m_rise = ce ? (m_snow & ~m_ref) : '0;
            m_fall = ce ? (~m_snow & m_ref) : '0;
            if (ce) begin
                m_ref = m_snow;
                m_q0  = dout0;
                m_oe  = oe_in;
`ifdef IO_BANK_DDR_EN
                m_q1 = dout1;
`else
                m_q1 = dout0;
`endif
                if (!latch) begin
                    m_din0 = m_snow;
`ifdef IO_BANK_DDR_EN
                    m_din1 = m_nsamp;
`endif
                end
            end
            for (int i = 0; i < W; i++) begin
                if (m_sync[i] != m_stab[i] && m_run[i] >= F)
                    m_stab[i] = m_sync[i];
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) m_nsamp = pin_val();
        #1;
        if (chk_en) begin
            chk("din0", din0, m_din0);
            chk("din1", din1, m_din1);
            chk("rise", rise, m_rise);
            chk("fall", fall, m_fall);
            chk("pin", pin & pin_known(), pin_val() & pin_known());
            if (pin_known()[0]) chk("global_out", gout, pin_val()[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_din0", din0, 0);
        chk("rst_rise", rise, 0);
        chk("rst_fall", fall, 0);
        chk("rst_din1", din1, 0);
        chk("rst_pin", pin, 0);
        #1 resetn = 1'b1;
        repeat (8) tick();

        // single held edge on channel 1
        #1 ext_val[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("edge_din0", din0[1], (k >= 6));
            chk("edge_rise", rise[1], (k == 6));
            chk("edge_fall", fall[1], 0);
            chk("edge_model", m_rise[1], (k == 6));
        end

        // two-cycle glitch on channel 2
        #1 ext_val[2] = 1'b1;
        tick();
        tick();
        #1 ext_val[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("glitch", {din0[2], rise[2], fall[2]}, 0);
        end

        // latched input still reports the edge
        #1 ext_val[0] = 1'b1;
        repeat (8) tick();
        chk("latch_pre", din0[0], 1);
        #1 latch = 1'b1;
        ext_val[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("latch_hold", din0[0], 1);
            chk("latch_fall", fall[0], (k == 6));
        end
        #1 latch = 1'b0;
        tick();
        chk("latch_rel", din0[0], 0);
        chk("latch_fall_end", fall[0], 0);

        // output drive, pull-up and clock_enable hold
        #1 oe_in = 4'b0001;
        dout0 = 4'b0001;
        dout1 = 4'b0001;
        ext_val = 4'b1011;
        tick();
        #1 ext_en = 4'b1100;
        tick();
        chk("drive_pin", pin, 4'b1011);
        chk("drive_gout", gout, 1);
        #1 ce = 1'b0;
        dout0 = '0;
        dout1 = '0;
        oe_in = '0;
        tick();
        chk("ce_hold_a", pin, 4'b1011);
        tick();
        chk("ce_hold_b", pin, 4'b1011);
        #1 ext_en = 4'b1101;
        ce = 1'b1;
        tick();

        // asynchronous reset while driving and filtering
        #1 oe_in = 4'b0010;
        tick();
        chk("drv_low", pin[1], 0);
        repeat (8) tick();
        chk("pre_rst_din0", din0, 4'b1001);
        chk("pre_rst_model", m_din0, 4'b1001);
        #1 ext_val[2] = 1'b1;
        tick();
        tick();
        tick();
        #1 resetn = 1'b0;
        oe_in = '0;
        #1;
        chk("arst_pin1", pin[1], 1);
        chk("arst_din0", din0, 0);
        chk("arst_rise", rise, 0);
        chk("arst_fall", fall, 0);
        chk("arst_din1", din1, 0);
        chk("arst_model", m_din0, 0);
        tick();
        tick();
        #1 resetn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("rel_din0", din0, (k >= 6) ? 4'b1111 : 4'b0000);
            chk("rel_rise", rise, (k == 6) ? 4'b1111 : 4'b0000);
        end

        // randomized traffic
        #1 oe_in = 4'b1000;
        dout0 = 4'b1000;
        dout1 = 4'b1000;
        tick();
        #1 ext_en = 4'b0101;
        for (int n = 0; n < 3000; n++) begin
            int rate;
            rate = n[7] ? 7 : 2;
            if ($urandom_range(rate) == 0) ext_val[0] = ~ext_val[0];
            if ($urandom_range(rate) == 0) ext_val[2] = ~ext_val[2];
            ce    = ($urandom_range(3) != 0);
            latch = ($urandom_range(4) == 0);
            dout0 = W'($urandom);
            dout1 = dout0;
            oe_in = {1'b1, 1'b0, 1'($urandom), 1'b0};
            tick();
            #1;
        end

`ifdef IO_BANK_DDR_EN
        chk_en = 1'b0;
        ce = 1'b1;
        latch = 1'b0;
        oe_in = 4'b0001;
        dout0 = 4'b0001;
        dout1 = 4'b0000;
        ext_en = 4'b0100;
        ext_val[2] = 1'b1;
        tick();
        tick();
        chk("ddr_hi", pin[0], 1);
        @(negedge clk);
        #1;
        chk("ddr_lo", pin[0], 0);
        tick();
        chk("ddr_in_hi", din1[2], 1);
        #1 ext_val[2] = 1'b0;
        tick();
        chk("ddr_in_lo", din1[2], 0);
`endif

        #1 chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
